// File: rtl/ll_fifo_drain_arb.sv
`default_nettype none
// ============================================================================
// Module   : ll_fifo_drain_arb
// Purpose  : Round-robin drain arbiter for a shared linked-list FIFO. It pops
//            the logical queues in turn, catches the returned word one cycle
//            later and presents it on a valid/ready output through a 2-entry
//            buffer. Pops are credit-limited so the buffer can never overflow.
// Ports    : clk          - clock, all state on posedge
//            rst_n        - asynchronous active-low reset
//            i_empty      - per-queue empty flags (registered in the FIFO)
//            i_fifo_data  - shared FIFO read data, valid one cycle after pop
//            i_drain_en   - allow new pops (in-flight data always drains)
//            o_pop        - pop strobe to the shared FIFO
//            o_pop_sel    - queue being popped (0 when o_pop is low)
//            o_m_valid    - output word available
//            o_m_data     - output payload
//            o_m_sel      - source queue of o_m_data
//            i_m_ready    - downstream accept
// Revision : 1.0 - initial release
// ============================================================================
module ll_fifo_drain_arb #(
  parameter int WIDTH     = 8,
  parameter int NUM_FIFOS = 2,
  parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_FIFOS-1:0] i_empty,
  input  logic [WIDTH-1:0]     i_fifo_data,
  input  logic                 i_drain_en,
  output logic                 o_pop,
  output logic [SEL_WIDTH-1:0] o_pop_sel,
  output logic                 o_m_valid,
  output logic [WIDTH-1:0]     o_m_data,
  output logic [SEL_WIDTH-1:0] o_m_sel,
  input  logic                 i_m_ready
);

  localparam logic [SEL_WIDTH:0] c_NUM = (SEL_WIDTH+1)'(NUM_FIFOS);

  // Arbitration state
  logic [SEL_WIDTH-1:0] r_rr_ptr;
  logic                 r_inflight;
  logic [SEL_WIDTH-1:0] r_inflight_sel;

  // 2-entry output buffer of {sel, data}
  logic [WIDTH-1:0]     r_buf_data [2];
  logic [SEL_WIDTH-1:0] r_buf_sel  [2];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;

  logic [1:0]           w_credits;
  logic                 w_bypass;
  logic                 w_xfer;
  logic                 w_buf_wr;
  logic                 w_buf_rd;
  logic                 w_space;
  logic                 w_pop;
  logic                 w_found;
  logic [SEL_WIDTH-1:0] w_grant;
  logic [SEL_WIDTH:0]   w_scan_idx;
  logic [SEL_WIDTH:0]   w_grant_inc;
  logic [SEL_WIDTH-1:0] w_rr_next;

  // Words owed to downstream: buffered plus the one returning from the FIFO.
  assign w_credits = r_count + {1'b0, r_inflight};

  // With the buffer empty, the returning word is presented directly so the
  // first word of a burst appears in the same cycle it returns.
  assign w_bypass  = (r_count == 2'd0) & r_inflight;
  assign o_m_valid = (r_count != 2'd0) | r_inflight;
  assign o_m_data  = w_bypass ? i_fifo_data    : r_buf_data[r_rd_ptr];
  assign o_m_sel   = w_bypass ? r_inflight_sel : r_buf_sel[r_rd_ptr];

  assign w_xfer   = o_m_valid & i_m_ready;
  assign w_buf_rd = w_xfer & (r_count != 2'd0);
  // A bypassed word that is accepted immediately never enters the buffer.
  assign w_buf_wr = r_inflight & ~(w_bypass & i_m_ready);

  // A full credit pool is still usable when one word leaves this cycle.
  assign w_space = (w_credits < 2'd2) | ((w_credits == 2'd2) & w_xfer);
  assign w_pop   = rst_n & i_drain_en & w_found & w_space;

  assign o_pop     = w_pop;
  assign o_pop_sel = w_pop ? w_grant : '0;

  // Round-robin scan starting at r_rr_ptr, wrapping modulo NUM_FIFOS.
  always_comb begin
    w_found    = 1'b0;
    w_grant    = '0;
    w_scan_idx = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      w_scan_idx = {1'b0, r_rr_ptr} + (SEL_WIDTH+1)'(i);
      if (w_scan_idx >= c_NUM) begin
        w_scan_idx = w_scan_idx - c_NUM;
      end
      if (!w_found && !i_empty[w_scan_idx[SEL_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_scan_idx[SEL_WIDTH-1:0];
      end
    end
  end

  assign w_grant_inc = {1'b0, w_grant} + (SEL_WIDTH+1)'(1);
  assign w_rr_next   = (w_grant_inc == c_NUM) ? '0 : w_grant_inc[SEL_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr       <= '0;
      r_inflight     <= 1'b0;
      r_inflight_sel <= '0;
      r_buf_data[0]  <= '0;
      r_buf_data[1]  <= '0;
      r_buf_sel[0]   <= '0;
      r_buf_sel[1]   <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_count        <= 2'd0;
    end else begin
      r_inflight <= w_pop;
      if (w_pop) begin
        r_rr_ptr       <= w_rr_next;
        r_inflight_sel <= w_grant;
      end
      if (w_buf_wr) begin
        r_buf_data[r_wr_ptr] <= i_fifo_data;
        r_buf_sel[r_wr_ptr]  <= r_inflight_sel;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_buf_rd) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_buf_wr, w_buf_rd})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ll_fifo_drain_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ll_fifo_drain_arb
// Purpose  : Self-checking bench for ll_fifo_drain_arb: per-cycle directed
//            vector table, a mid-operation reset sequence and a randomized
//            run against a model of the shared FIFO queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ll_fifo_drain_arb;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int SW = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  i_empty = '1;
  logic [W-1:0]  i_fifo_data = '0;
  logic          i_drain_en = 1'b0;
  logic          o_pop;
  logic [SW-1:0] o_pop_sel;
  logic          o_m_valid;
  logic [W-1:0]  o_m_data;
  logic [SW-1:0] o_m_sel;
  logic          i_m_ready = 1'b0;

  always #5 clk = ~clk;

  ll_fifo_drain_arb #(.WIDTH(W), .NUM_FIFOS(N), .SEL_WIDTH(SW)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_empty     (i_empty),
    .i_fifo_data (i_fifo_data),
    .i_drain_en  (i_drain_en),
    .o_pop       (o_pop),
    .o_pop_sel   (o_pop_sel),
    .o_m_valid   (o_m_valid),
    .o_m_data    (o_m_data),
    .o_m_sel     (o_m_sel),
    .i_m_ready   (i_m_ready)
  );

  typedef struct {
    logic          rst_n;
    logic [N-1:0]  empty;
    logic [W-1:0]  fd;
    logic          drain;
    logic          rdy;
    logic          pop;
    logic [SW-1:0] psel;
    logic          valid;
    logic [W-1:0]  data;
    logic [SW-1:0] msel;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void add(input logic r, input logic [N-1:0] e, input logic [W-1:0] fd,
                              input logic d, input logic rd, input logic p, input logic [SW-1:0] ps,
                              input logic v, input logic [W-1:0] md, input logic [SW-1:0] ms);
    vec_t t;
    t.rst_n = r; t.empty = e; t.fd = fd; t.drain = d; t.rdy = rd;
    t.pop = p; t.psel = ps; t.valid = v; t.data = md; t.msel = ms;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Random-phase model state
  logic [W-1:0]  mq [N][$];
  logic [8:0]    sb [$];
  logic [SW-1:0] rr_m;
  logic [W-1:0]  next_fd;
  logic          prev_stall;
  logic [8:0]    prev_head;
  int            seq;

  initial begin
    // ---------------- directed table ----------------
    //    rst empty  fd    drn rdy | pop ps v  data  ms
    // single queue with two words
    add(0, 2'b10, 8'h00, 1, 1,   0, 0, 0, 8'h00, 0);
    add(1, 2'b10, 8'h00, 1, 1,   1, 0, 0, 8'h00, 0);
    add(1, 2'b10, 8'hA1, 1, 1,   1, 0, 1, 8'hA1, 0);
    add(1, 2'b11, 8'hB2, 1, 1,   0, 0, 1, 8'hB2, 0);
    add(1, 2'b11, 8'h55, 1, 1,   0, 0, 0, 8'h00, 0);
    // both queues busy: alternating grants, full throughput
    add(0, 2'b00, 8'h00, 1, 1,   0, 0, 0, 8'h00, 0);
    add(1, 2'b00, 8'h00, 1, 1,   1, 0, 0, 8'h00, 0);
    add(1, 2'b00, 8'h10, 1, 1,   1, 1, 1, 8'h10, 0);
    add(1, 2'b00, 8'h20, 1, 1,   1, 0, 1, 8'h20, 1);
    add(1, 2'b00, 8'h11, 1, 1,   1, 1, 1, 8'h11, 0);
    add(1, 2'b00, 8'h21, 0, 1,   0, 0, 1, 8'h21, 1);
    add(1, 2'b00, 8'h55, 0, 1,   0, 0, 0, 8'h00, 0);
    // backpressure: two pops then stall, resume on first transfer
    add(0, 2'b00, 8'h00, 1, 0,   0, 0, 0, 8'h00, 0);
    add(1, 2'b00, 8'h00, 1, 0,   1, 0, 0, 8'h00, 0);
    add(1, 2'b00, 8'h10, 1, 0,   1, 1, 1, 8'h10, 0);
    add(1, 2'b00, 8'h20, 1, 0,   0, 0, 1, 8'h10, 0);
    add(1, 2'b00, 8'h55, 1, 0,   0, 0, 1, 8'h10, 0);
    add(1, 2'b00, 8'h55, 1, 1,   1, 0, 1, 8'h10, 0);
    add(1, 2'b00, 8'h11, 1, 1,   1, 1, 1, 8'h20, 1);
    add(1, 2'b00, 8'h21, 0, 1,   0, 0, 1, 8'h11, 0);
    add(1, 2'b00, 8'h55, 0, 1,   0, 0, 1, 8'h21, 1);
    add(1, 2'b00, 8'h55, 0, 1,   0, 0, 0, 8'h00, 0);
    // drain_en dropped right after a pop
    add(0, 2'b10, 8'h00, 1, 1,   0, 0, 0, 8'h00, 0);
    add(1, 2'b10, 8'h00, 1, 1,   1, 0, 0, 8'h00, 0);
    add(1, 2'b10, 8'hA1, 0, 1,   0, 0, 1, 8'hA1, 0);
    add(1, 2'b10, 8'h55, 0, 1,   0, 0, 0, 8'h00, 0);
    add(1, 2'b10, 8'h55, 1, 1,   1, 0, 0, 8'h00, 0);
    add(1, 2'b10, 8'hB2, 0, 1,   0, 0, 1, 8'hB2, 0);
    add(1, 2'b10, 8'h55, 0, 1,   0, 0, 0, 8'h00, 0);
    // pointer skips an empty queue and wraps
    add(0, 2'b01, 8'h00, 1, 1,   0, 0, 0, 8'h00, 0);
    add(1, 2'b01, 8'h00, 1, 1,   1, 1, 0, 8'h00, 0);
    add(1, 2'b00, 8'hC3, 1, 1,   1, 0, 1, 8'hC3, 1);
    add(1, 2'b11, 8'hD4, 1, 1,   0, 0, 1, 8'hD4, 0);
    add(1, 2'b11, 8'h55, 1, 1,   0, 0, 0, 8'h00, 0);

    repeat (2) @(posedge clk);
    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge clk); #1;
      rst_n       = vecs[k].rst_n;
      i_empty     = vecs[k].empty;
      i_fifo_data = vecs[k].fd;
      i_drain_en  = vecs[k].drain;
      i_m_ready   = vecs[k].rdy;
      @(negedge clk);
      check($sformatf("v%0d pop", k), 32'(o_pop), 32'(vecs[k].pop));
      check($sformatf("v%0d pop_sel", k), 32'(o_pop_sel), 32'(vecs[k].psel));
      check($sformatf("v%0d m_valid", k), 32'(o_m_valid), 32'(vecs[k].valid));
      if (vecs[k].valid || !vecs[k].rst_n) begin
        check($sformatf("v%0d m_data", k), 32'(o_m_data), 32'(vecs[k].data));
        check($sformatf("v%0d m_sel", k), 32'(o_m_sel), 32'(vecs[k].msel));
      end
    end

    // ---------------- reset with two buffered words ----------------
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; i_empty = 2'b00; i_drain_en = 1'b1; i_m_ready = 1'b0; i_fifo_data = 8'h00;
    @(posedge clk); #1; i_fifo_data = 8'h10;
    @(posedge clk); #1; i_fifo_data = 8'h20;
    @(posedge clk); #1; i_fifo_data = 8'h55;
    @(negedge clk);
    check("prerst m_valid", 32'(o_m_valid), 32'd1);
    check("prerst m_data", 32'(o_m_data), 32'h10);
    check("prerst pop", 32'(o_pop), 32'd0);
    #2; rst_n = 1'b0;
    #1;
    check("asyncrst m_valid", 32'(o_m_valid), 32'd0);
    check("asyncrst m_data", 32'(o_m_data), 32'd0);
    check("asyncrst m_sel", 32'(o_m_sel), 32'd0);
    check("asyncrst pop", 32'(o_pop), 32'd0);
    check("asyncrst pop_sel", 32'(o_pop_sel), 32'd0);
    @(posedge clk); #1;
    i_empty = 2'b11; i_m_ready = 1'b1; rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("postrst%0d m_valid", c), 32'(o_m_valid), 32'd0);
      check($sformatf("postrst%0d pop", c), 32'(o_pop), 32'd0);
      @(posedge clk); #1;
    end

    // ---------------- randomized run against queue model ----------------
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rr_m = '0; next_fd = '0; prev_stall = 1'b0; prev_head = '0; seq = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) != 0) begin
        int q;
        q = $urandom_range(0, N - 1);
        if (mq[q].size() < 6) begin
          mq[q].push_back({q[0], seq[6:0]});
          seq++;
        end
      end
      for (int q = 0; q < N; q++) i_empty[q] = (mq[q].size() == 0);
      i_fifo_data = next_fd;
      next_fd     = W'($urandom);
      i_m_ready   = ($urandom_range(0, 3) != 0);
      i_drain_en  = ($urandom_range(0, 7) != 0);
      @(negedge clk);
      begin
        logic          any;
        logic          exp_pop;
        logic          found;
        logic [SW-1:0] gnt;
        any     = (i_empty != '1);
        exp_pop = i_drain_en && any &&
                  (sb.size() < 2 || (sb.size() == 2 && i_m_ready));
        check("rnd m_valid", 32'(o_m_valid), 32'(sb.size() != 0));
        if (prev_stall)
          check("rnd hold", 32'({o_m_sel, o_m_data}), 32'(prev_head));
        check("rnd pop", 32'(o_pop), 32'(exp_pop));
        found = 1'b0; gnt = '0;
        for (int i = 0; i < N; i++) begin
          int idx;
          idx = (int'(rr_m) + i) % N;
          if (!found && mq[idx].size() != 0) begin
            found = 1'b1;
            gnt   = SW'(idx);
          end
        end
        if (exp_pop) check("rnd pop_sel", 32'(o_pop_sel), 32'(gnt));
        if (o_m_valid && i_m_ready && sb.size() != 0) begin
          check("rnd out", 32'({o_m_sel, o_m_data}), 32'(sb[0]));
          void'(sb.pop_front());
        end
        if (o_pop) begin
          check("rnd pop_nonempty", 32'(mq[o_pop_sel].size() != 0), 32'd1);
          if (mq[o_pop_sel].size() != 0) begin
            next_fd = mq[o_pop_sel].pop_front();
            sb.push_back({o_pop_sel, next_fd});
          end
          rr_m = (o_pop_sel == SW'(N - 1)) ? '0 : o_pop_sel + SW'(1);
        end
        check("rnd credits", 32'(sb.size() <= 2), 32'd1);
        prev_stall = o_m_valid & ~i_m_ready;
        prev_head  = {o_m_sel, o_m_data};
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
